// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// The serial input passes through a two-flop synchroniser. A small FSM
// samples each bit in the middle of its bit period. Complete frames are
// pushed into the FIFO. Framing and overrun problems are latched as sticky
// flags.
`timescale 1ns/1ps

module uart_rx_fifo #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_uart_rx,
    input  logic                          i_rd_en,
    output logic [7:0]                    o_rd_data,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_overrun,
    input  logic                          i_clr_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int CW           = PTR_W + 1;
    localparam int SYNC_STAGES  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   rx_s;

    assign sync_next[0] = i_uart_rx;
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    // Shift the line through the synchroniser; idle-high after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t          state_reg;
    logic [CNT_W-1:0]   baud_cnt_reg;
    logic [2:0]         bit_cnt_reg;
    logic [7:0]         shift_reg;
    logic               baud_done;
    logic               push;
    logic               frame_set;

    assign baud_done = (baud_cnt_reg == CNT_W'(CLKS_PER_BIT - 1));
    // The stop bit is sampled on the same edge that writes the FIFO.
    assign push      = (state_reg == ST_STOP) && baud_done && rx_s;
    assign frame_set = (state_reg == ST_STOP) && baud_done && !rx_s;

    // Frame sequencing: start qualification, mid-bit data sampling, stop check
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_reg    <= ST_START;
                        baud_cnt_reg <= '0;
                    end
                end
                ST_START: begin
                    if (baud_cnt_reg == CNT_W'(HALF_BIT - 1)) begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        // A line that is high again at mid-start was a glitch.
                        state_reg    <= rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= {rx_s, shift_reg[7:1]};
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // Hold here until the line recovers so a long low
                    // level reports only a single framing error.
                    if (rx_s) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Byte FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             empty;
    logic             full;
    logic             pop;
    logic             wr_en;
    logic             overrun_set;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CW'(FIFO_DEPTH));
    assign pop         = i_rd_en && !empty;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    assign wr_en       = push && (!full || pop);
    assign overrun_set = push && full && !pop;

    // Occupancy follows the net effect of this cycle's push and pop
    always_comb begin
        count_next = count_reg;
        case ({wr_en, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage write; contents need no reset because the pointers gate them
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic frame_err_reg;
    logic overrun_reg;

    // A new error event wins over a clear arriving on the same edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_reg <= 1'b1;
            end else if (i_clr_err) begin
                frame_err_reg <= 1'b0;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (i_clr_err) begin
                overrun_reg <= 1'b0;
            end
        end
    end

    assign o_rd_valid  = !empty;
    assign o_count     = count_reg;
    assign o_rd_data   = empty ? 8'h00 : mem[rd_ptr_reg];
    assign o_frame_err = frame_err_reg;
    assign o_overrun   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed 8N1 frames against a queue-based reference model.
// The bench drives each frame itself, so it knows the cycle where each
// frame ends. The model records the outcome of every frame against that
// cycle. A per-cycle compare process checks the DUT outputs against the
// model. Literal expectations pin the key results of each scenario.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    // 2 sync flops + half bit + 8 data bits + stop bit, in cycles from the
    // cycle where the line is first driven low (CLKS_PER_BIT = 10).
    localparam int STOP_LAT = 98;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] count;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ    (1000000),
        .BAUD      (100000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_uart_rx  (rx),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_count    (count),
        .o_frame_err(frame_err),
        .o_overrun  (overrun),
        .i_clr_err  (clr_err)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        bit         err;
    } ev_t;

    int         n_checks = 0;
    int         n_fail = 0;
    int         cyc = 0;
    bit         live = 1'b0;
    logic [7:0] q[$];
    ev_t        sched[$];
    ev_t        ev;
    bit         m_fe = 1'b0;
    bit         m_ov = 1'b0;
    bit         m_pop;
    bit         m_push;
    bit         m_err;
    bit         m_drop;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    task automatic clear_flags();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    // One 8N1 frame. stop_low > 0 holds the stop bit low that many cycles
    // (frame error). pop_at_stop raises i_rd_en for the stop-sample cycle.
    task automatic send_byte(input logic [7:0] d, input int stop_low, input bit pop_at_stop);
        int n;
        n  = cyc;
        rx = 1'b0;
        if (stop_low > 0) sched.push_back('{n + STOP_LAT, 8'h00, 1'b1});
        else              sched.push_back('{n + STOP_LAT, d, 1'b0});
        tick(10);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(10);
        end
        if (stop_low > 0) begin
            rx = 1'b0;
            tick(stop_low);
        end
        rx = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rd_en = pop_at_stop && (cyc == n + STOP_LAT - 1);
            tick(1);
        end
        rd_en = 1'b0;
    endtask

    // Reference model: FIFO as a queue, frame outcomes applied at their end cycle
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            sched.delete();
            m_fe = 1'b0;
            m_ov = 1'b0;
            live = 1'b1;
        end else begin
            m_pop  = rd_en && (q.size() > 0);
            m_push = 1'b0;
            m_err  = 1'b0;
            if (sched.size() > 0 && sched[0].cyc == cyc) begin
                ev = sched.pop_front();
                if (ev.err) m_err = 1'b1;
                else        m_push = 1'b1;
            end
            m_drop = m_push && (q.size() == DEPTH) && !m_pop;
            if (clr_err) begin
                m_fe = 1'b0;
                m_ov = 1'b0;
            end
            if (m_err)  m_fe = 1'b1;
            if (m_drop) m_ov = 1'b1;
            if (m_pop)  void'(q.pop_front());
            if (m_push && !m_drop) q.push_back(ev.d);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (live) begin
            check("cyc_valid", 32'(rd_valid), 32'(q.size() > 0));
            check("cyc_count", 32'(count), 32'(q.size()));
            if (q.size() > 0) check("cyc_data", 32'(rd_data), 32'(q[0]));
            check("cyc_frame_err", 32'(frame_err), 32'(m_fe));
            check("cyc_overrun", 32'(overrun), 32'(m_ov));
        end
    end

    initial begin
        logic [7:0] part;
        tick(3);
        check("rst_valid", 32'(rd_valid), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_data", 32'(rd_data), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        rst = 1'b0;
        tick(5);

        // Single byte, then pop
        send_byte(8'hA5, 0, 1'b0);
        check("a5_valid", 32'(rd_valid), 32'h1);
        check("a5_data", 32'(rd_data), 32'hA5);
        check("a5_count", 32'(count), 32'h1);
        pop_one();
        check("a5_pop_valid", 32'(rd_valid), 32'h0);
        check("a5_pop_count", 32'(count), 32'h0);

        // Short low glitch on an idle line
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(20);
        check("glitch_count", 32'(count), 32'h0);
        check("glitch_frame_err", 32'(frame_err), 32'h0);

        // Stop bit held low: one framing error, then recovery
        send_byte(8'h3C, 30, 1'b0);
        tick(5);
        check("ferr_flag", 32'(frame_err), 32'h1);
        check("ferr_count", 32'(count), 32'h0);
        clear_flags();
        check("ferr_clr", 32'(frame_err), 32'h0);
        send_byte(8'h55, 0, 1'b0);
        check("after_ferr_data", 32'(rd_data), 32'h55);
        check("after_ferr_count", 32'(count), 32'h1);
        pop_one();

        // 17 bytes, no pops: last one lost
        for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 0, 1'b0);
        check("ovr_count", 32'(count), 32'd16);
        check("ovr_flag", 32'(overrun), 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            check("ovr_seq", 32'(rd_data), 32'(i));
            pop_one();
        end
        check("ovr_empty", 32'(rd_valid), 32'h0);
        clear_flags();
        check("ovr_clr", 32'(overrun), 32'h0);

        // Full FIFO with a pop on the stop-sample cycle
        for (int i = 0; i < DEPTH; i++) send_byte(8'h60 + 8'(i), 0, 1'b0);
        check("full_count", 32'(count), 32'd16);
        send_byte(8'h77, 0, 1'b1);
        check("full_pop_count", 32'(count), 32'd16);
        check("full_pop_overrun", 32'(overrun), 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            check("full_pop_seq", 32'(rd_data), (i < DEPTH - 1) ? 32'(8'h61 + 8'(i)) : 32'h77);
            pop_one();
        end

        // Reset in the middle of a frame with a byte held and a flag set
        send_byte(8'h42, 0, 1'b0);
        send_byte(8'hC3, 12, 1'b0);
        tick(5);
        check("pre_rst_count", 32'(count), 32'h1);
        check("pre_rst_ferr", 32'(frame_err), 32'h1);
        part = 8'hE7;
        rx = 1'b0;
        tick(10);
        for (int i = 0; i < 4; i++) begin
            rx = part[i];
            tick(10);
        end
        rx = part[4];
        tick(5);
        rst = 1'b1;
        rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(5);
        check("mid_rst_count", 32'(count), 32'h0);
        check("mid_rst_ferr", 32'(frame_err), 32'h0);
        send_byte(8'h81, 0, 1'b0);
        check("post_rst_count", 32'(count), 32'h1);
        check("post_rst_data", 32'(rd_data), 32'h81);
        check("post_rst_ferr", 32'(frame_err), 32'h0);
        check("post_rst_overrun", 32'(overrun), 32'h0);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
